// File: rtl/prm_oblgc_pkg.sv
// Shared types and defaults for the obligation-check scan engine.
// Holds the query width, result word width, FSM states and the query vector type.
package prm_oblgc_pkg;

  localparam int QW = 15;
  localparam int PW = 16;
  localparam int CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  typedef logic [QW-1:0] query_t;

endpackage

// File: rtl/prm_oblgc_pack.sv
// Bit packer: drops one checker mask per sampled cycle into the word register at the slot position.
// Word is complete the same cycle its final bit is sampled; upstream holds it until the emit handshake clears it.
module prm_oblgc_pack #(
  parameter int PW = prm_oblgc_pkg::PW,
  parameter int CW = prm_oblgc_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_sample,
  input  logic          i_mask,
  input  logic [CW-1:0] i_remaining,
  output logic [PW-1:0] o_word,
  output logic          o_done
);

  localparam int SW = (PW > 1) ? $clog2(PW) : 1;

  logic [SW-1:0] r_slot;
  logic [PW-1:0] r_word;
  logic          w_full;
  logic          w_last;

  assign w_full = (r_slot == SW'(PW - 1));
  assign w_last = (i_remaining == CW'(1));
  assign o_done = i_sample && (w_full || w_last);
  assign o_word = r_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      // Clearing between words is what keeps the unused bits of a short final word at zero.
      r_slot <= '0;
      r_word <= '0;
    end else if (i_sample) begin
      r_word[r_slot] <= i_mask;
      r_slot         <= r_slot + SW'(1);
    end
  end

endmodule

// File: rtl/prm_oblgc_scan.sv
// Walks cmd_count consecutive query vectors past an external checker, one per cycle, packing masks into PW-bit words.
// First query is presented the cycle after accept; each word is held in EMIT until res_ready, stalling the scan.
module prm_oblgc_scan #(
  parameter int QW = prm_oblgc_pkg::QW,
  parameter int PW = prm_oblgc_pkg::PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [QW-1:0] cmd_base,
  input  logic [15:0]   cmd_count,
  output logic [QW-1:0] chk_q,
  input  logic          chk_mask,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [PW-1:0] res_data,
  output logic [QW-1:0] res_idx,
  output logic          res_last,
  output logic [15:0]   hit_cnt,
  output logic          busy
);

  import prm_oblgc_pkg::*;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [QW-1:0] r_chk_q;
  logic [QW-1:0] r_res_idx;
  logic [15:0]   r_remaining;
  logic [15:0]   r_hit_cnt;
  logic          r_res_last;

  logic          w_accept;
  logic          w_start;
  logic          w_sample;
  logic          w_emit_hs;
  logic          w_clr;
  logic          w_done;
  logic [PW-1:0] w_word;

  assign w_accept  = cmd_valid && (r_state == ST_IDLE);
  assign w_start   = w_accept && (cmd_count != 16'd0);
  assign w_sample  = (r_state == ST_SCAN);
  assign w_emit_hs = (r_state == ST_EMIT) && res_ready;
  assign w_clr     = w_start || w_emit_hs;

  prm_oblgc_pack #(.PW(PW), .CW(16)) u_pack (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_clr),
    .i_sample    (w_sample),
    .i_mask      (chk_mask),
    .i_remaining (r_remaining),
    .o_word      (w_word),
    .o_done      (w_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_done)  w_state_nxt = ST_EMIT;
      ST_EMIT: if (res_ready) w_state_nxt = (r_remaining == 16'd0) ? ST_IDLE : ST_SCAN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chk_q     <= '0;
      r_res_idx   <= '0;
      r_remaining <= '0;
      r_hit_cnt   <= '0;
      r_res_last  <= 1'b0;
    end else begin
      if (w_accept) r_hit_cnt <= '0;
      if (w_start) begin
        r_chk_q     <= cmd_base;
        r_res_idx   <= cmd_base;
        r_remaining <= cmd_count;
        r_res_last  <= 1'b0;
      end
      if (w_sample) begin
        r_chk_q     <= r_chk_q + QW'(1);
        r_remaining <= r_remaining - 16'd1;
        if (chk_mask && (r_hit_cnt != 16'hFFFF)) r_hit_cnt <= r_hit_cnt + 16'd1;
        if (r_remaining == 16'd1) r_res_last <= 1'b1;
      end
      // The next word starts at whatever query the scan paused on.
      if (w_emit_hs) begin
        r_res_last <= 1'b0;
        r_res_idx  <= r_chk_q;
      end
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign res_valid = (r_state == ST_EMIT);
  assign chk_q     = r_chk_q;
  assign res_data  = w_word;
  assign res_idx   = r_res_idx;
  assign res_last  = r_res_last;
  assign hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_prm_oblgc_scan.sv
// Self-checking bench: directed and random scan commands compared against a per-query reference model.
module tb_prm_oblgc_scan;

  localparam int QW = 15;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [QW-1:0] cmd_base;
  logic [15:0]   cmd_count;
  logic [QW-1:0] chk_q;
  logic          chk_mask;
  logic          res_valid;
  logic          res_ready;
  logic [PW-1:0] res_data;
  logic [QW-1:0] res_idx;
  logic          res_last;
  logic [15:0]   hit_cnt;
  logic          busy;

  int            n_checks = 0;
  int            n_errors = 0;
  int            mask_mode = 0;
  logic [QW-1:0] mask_key = '0;

  typedef struct {
    logic [PW-1:0] data;
    logic [QW-1:0] idx;
    logic          last;
  } word_t;

  word_t         exp_words[$];
  logic [QW-1:0] exp_q[$];
  int            exp_hits;

  always #5 clk = ~clk;

  prm_oblgc_scan #(.QW(QW), .PW(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_count (cmd_count),
    .chk_q     (chk_q),
    .chk_mask  (chk_mask),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_last  (res_last),
    .hit_cnt   (hit_cnt),
    .busy      (busy)
  );

  // Checker stub: 0 -> q[0], 1 -> always hit, 2 -> parity of q under a key.
  function automatic logic mask_of(input logic [QW-1:0] q);
    case (mask_mode)
      0:       return q[0];
      1:       return 1'b1;
      default: return ^(q & mask_key);
    endcase
  endfunction

  assign chk_mask = mask_of(chk_q);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_model(input logic [QW-1:0] base, input int count);
    int nw;
    word_t w;
    logic [QW-1:0] q;
    exp_words.delete();
    exp_q.delete();
    exp_hits = 0;
    nw = (count + PW - 1) / PW;
    for (int wi = 0; wi < nw; wi++) begin
      w.data = '0;
      w.idx  = QW'((int'(base) + wi * PW) % (1 << QW));
      w.last = (wi == nw - 1);
      for (int k = 0; k < PW; k++) begin
        if (wi * PW + k < count) begin
          q = QW'((int'(base) + wi * PW + k) % (1 << QW));
          w.data[k] = mask_of(q);
          exp_hits += int'(mask_of(q));
          exp_q.push_back(q);
        end
      end
      exp_words.push_back(w);
    end
  endtask

  task automatic run_cmd(input logic [QW-1:0] base, input int count, input int stall, input bit pulse);
    int  budget;
    int  stall_cnt;
    bit  done;
    build_model(base, count);
    budget = count + exp_words.size() * (stall + 2) + 20;
    stall_cnt = 0;
    done = 0;
    @(negedge clk);
    check_eq("accept_rdy", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_count = 16'(count);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_base  = QW'($urandom);
    cmd_count = 16'($urandom);
    if (count == 0) begin
      check_eq("zero_busy", 32'(busy), 32'd0);
      check_eq("zero_rdy", 32'(cmd_ready), 32'd1);
      check_eq("zero_hits", 32'(hit_cnt), 32'd0);
    end
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) @(negedge clk);
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      if (!busy) begin
        done = 1;
        break;
      end
      if (pulse && (cyc == 2 || cyc == 3)) begin
        cmd_valid = 1'b1;
        cmd_base  = QW'($urandom);
        cmd_count = 16'd5;
        check_eq("busy_rdy", 32'(cmd_ready), 32'd0);
      end
      if (res_valid) begin
        if (exp_words.size() == 0) begin
          check_eq("extra_word", 32'(exp_words.size()), 32'd1);
          res_ready = 1'b1;
        end else begin
          check_eq("res_data", 32'(res_data), 32'(exp_words[0].data));
          check_eq("res_idx", 32'(res_idx), 32'(exp_words[0].idx));
          check_eq("res_last", 32'(res_last), 32'(exp_words[0].last));
          if (stall_cnt < stall) begin
            stall_cnt++;
          end else begin
            stall_cnt = 0;
            res_ready = 1'b1;
            if (exp_words[0].last) check_eq("hit_cnt", 32'(hit_cnt), 32'(exp_hits));
            void'(exp_words.pop_front());
          end
        end
      end else if (exp_q.size() == 0) begin
        check_eq("extra_query", 32'(chk_q), 32'h7FFF_FFFF);
      end else begin
        check_eq("chk_q", 32'(chk_q), 32'(exp_q.pop_front()));
      end
    end
    check_eq("cmd_done", 32'(done), 32'd1);
    check_eq("words_left", 32'(exp_words.size()), 32'd0);
    check_eq("queries_left", 32'(exp_q.size()), 32'd0);
    check_eq("idle_rdy", 32'(cmd_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_vld"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_last"}, 32'(res_last), 32'd0);
    check_eq({tag, "_data"}, 32'(res_data), 32'd0);
    check_eq({tag, "_idx"}, 32'(res_idx), 32'd0);
    check_eq({tag, "_q"}, 32'(chk_q), 32'd0);
    check_eq({tag, "_hits"}, 32'(hit_cnt), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_count = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;

    mask_mode = 0; run_cmd(15'h0000, 16, 0, 0);
    mask_mode = 1; run_cmd(15'h7FFE, 4, 0, 0);
    mask_mode = 1; run_cmd(15'h0010, 40, 5, 0);
    mask_mode = 1; run_cmd(15'h1234, 0, 0, 0);
    mask_mode = 2; mask_key = 15'h5A5A; run_cmd(15'h7FF0, 33, 1, 1);

    // Abort a 32-query command mid-scan, then confirm a fresh command runs cleanly.
    mask_mode = 1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 15'h0100; cmd_count = 16'd32;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("abort_quiet", 32'({busy, res_valid}), 32'd0);
    end
    run_cmd(15'h0200, 20, 2, 0);

    for (int n = 0; n < 10; n++) begin
      mask_mode = int'($urandom_range(0, 2));
      mask_key  = QW'($urandom);
      run_cmd(QW'($urandom), int'($urandom_range(0, 50)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
